// File: rtl/cam_color_pkg.sv
// cam_color_pkg: colour codes and RGB565 field positions for the colour classifier
package cam_color_pkg;
    localparam logic [2:0] COLOR_NONE  = 3'b000;
    localparam logic [2:0] COLOR_RED   = 3'b100;
    localparam logic [2:0] COLOR_GREEN = 3'b010;
    localparam logic [2:0] COLOR_BLUE  = 3'b001;
    localparam int R_MSB = 15;
    localparam int R_LSB = 11;
    localparam int G_MSB = 10;
    localparam int G_LSB = 6;
    localparam int B_MSB = 4;
    localparam int B_LSB = 0;
endpackage

// File: rtl/cam_pixel_classify.sv
// cam_pixel_classify: one-hot {red,green,blue} dominance test of an RGB565 pixel
module cam_pixel_classify
    import cam_color_pkg::*;
#(
    parameter int DOM_MARGIN = 4
)(
    input  logic [15:0] i_pix,
    output logic [2:0]  o_class
);
    logic [5:0] w_r, w_g, w_b, w_m;
    logic       w_unused;
    // green is reduced to its top 5 bits so all channels share one scale
    assign w_r = {1'b0, i_pix[R_MSB:R_LSB]};
    assign w_g = {1'b0, i_pix[G_MSB:G_LSB]};
    assign w_b = {1'b0, i_pix[B_MSB:B_LSB]};
    assign w_m = 6'(DOM_MARGIN);
    assign w_unused = i_pix[G_LSB-1];
    assign o_class = {w_r >= w_g + w_m && w_r >= w_b + w_m,
                      w_g >= w_r + w_m && w_g >= w_b + w_m,
                      w_b >= w_r + w_m && w_b >= w_g + w_m};
endmodule

// File: rtl/cam_color_classifier.sv
// cam_color_classifier: xclk generation, OV7670 pixel capture and per-frame dominant colour
module cam_color_classifier
    import cam_color_pkg::*;
#(
    parameter int XCLK_DIV   = 2,
    parameter int DOM_MARGIN = 4,
    parameter int MIN_PIXELS = 64,
    parameter int CNT_W      = 20
)(
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] camera_data,
    input  logic       pclk,
    input  logic       href,
    input  logic       vsync,
    output logic [2:0] color_code,
    output logic       xclk
);
    localparam int DIV_W = $clog2(XCLK_DIV + 1);
    logic [DIV_W-1:0] r_div;
    logic             r_xclk;
    logic [1:0]       r_pclk_s, r_href_s, r_vsync_s;
    logic [7:0]       r_data_s1, r_data_s2, r_hi;
    logic             r_pclk_prev, r_vsync_prev, r_phase, r_pix_vld;
    logic [15:0]      r_pix;
    logic [CNT_W-1:0] r_cnt_r, r_cnt_g, r_cnt_b;
    logic [2:0]       r_code, w_class, w_decision;
    logic             w_div_end, w_pclk_rise, w_vsync_rise;

    assign w_div_end    = r_div == DIV_W'(XCLK_DIV - 1);
    assign w_pclk_rise  = r_pclk_s[1] & ~r_pclk_prev;
    assign w_vsync_rise = r_vsync_s[1] & ~r_vsync_prev;
    assign color_code   = r_code;
    assign xclk         = r_xclk;

    cam_pixel_classify #(.DOM_MARGIN(DOM_MARGIN)) u_classify (
        .i_pix   (r_pix),
        .o_class (w_class)
    );

    // winner must reach the minimum and strictly beat both other classes
    always_comb begin
        w_decision = (r_cnt_r >= CNT_W'(MIN_PIXELS) && r_cnt_r > r_cnt_g && r_cnt_r > r_cnt_b) ? COLOR_RED :
                     (r_cnt_g >= CNT_W'(MIN_PIXELS) && r_cnt_g > r_cnt_r && r_cnt_g > r_cnt_b) ? COLOR_GREEN :
                     (r_cnt_b >= CNT_W'(MIN_PIXELS) && r_cnt_b > r_cnt_r && r_cnt_b > r_cnt_g) ? COLOR_BLUE :
                     COLOR_NONE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_div        <= '0;
            r_xclk       <= 1'b0;
            r_pclk_s     <= '0;
            r_href_s     <= '0;
            r_vsync_s    <= '0;
            r_data_s1    <= '0;
            r_data_s2    <= '0;
            r_pclk_prev  <= 1'b0;
            r_vsync_prev <= 1'b0;
            r_phase      <= 1'b0;
            r_hi         <= '0;
            r_pix        <= '0;
            r_pix_vld    <= 1'b0;
            r_cnt_r      <= '0;
            r_cnt_g      <= '0;
            r_cnt_b      <= '0;
            r_code       <= COLOR_NONE;
        end else begin
            r_div        <= w_div_end ? '0 : r_div + 1'b1;
            r_xclk       <= w_div_end ? ~r_xclk : r_xclk;
            r_pclk_s     <= {r_pclk_s[0], pclk};
            r_href_s     <= {r_href_s[0], href};
            r_vsync_s    <= {r_vsync_s[0], vsync};
            r_data_s1    <= camera_data;
            r_data_s2    <= r_data_s1;
            r_pclk_prev  <= r_pclk_s[1];
            r_vsync_prev <= r_vsync_s[1];
            // line end or blanking realigns the byte phase, dropping any odd byte
            if (!r_href_s[1] || r_vsync_s[1]) begin
                r_phase <= 1'b0;
            end else if (w_pclk_rise) begin
                r_phase <= ~r_phase;
                if (r_phase) r_pix <= {r_hi, r_data_s2};
                else r_hi <= r_data_s2;
            end
            r_pix_vld <= w_pclk_rise & r_href_s[1] & ~r_vsync_s[1] & r_phase;
            // frame end wins over a pending pixel so nothing leaks into the next frame
            if (w_vsync_rise) begin
                r_code  <= w_decision;
                r_cnt_r <= '0;
                r_cnt_g <= '0;
                r_cnt_b <= '0;
            end else if (r_pix_vld) begin
                r_cnt_r <= r_cnt_r + CNT_W'(w_class[2] && ~&r_cnt_r);
                r_cnt_g <= r_cnt_g + CNT_W'(w_class[1] && ~&r_cnt_g);
                r_cnt_b <= r_cnt_b + CNT_W'(w_class[0] && ~&r_cnt_b);
            end
        end
    end
endmodule

// File: tb/tb_cam_color_classifier.sv
// tb_cam_color_classifier: directed and randomized frame checks against a colour model
module tb_cam_color_classifier;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] camera_data = '0;
    logic       pclk = 1'b0;
    logic       href = 1'b0;
    logic       vsync = 1'b0;
    logic [2:0] color_code;
    logic       xclk;
    int         tests = 0;
    int         fails = 0;

    cam_color_classifier dut (
        .clk         (clk),
        .reset       (reset),
        .camera_data (camera_data),
        .pclk        (pclk),
        .href        (href),
        .vsync       (vsync),
        .color_code  (color_code),
        .xclk        (xclk)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] m_class(input logic [15:0] p);
        int r, g, b;
        r = int'(p[15:11]);
        g = int'(p[10:5]) / 2;
        b = int'(p[4:0]);
        if (r >= g + 4 && r >= b + 4) return 3'b100;
        if (g >= r + 4 && g >= b + 4) return 3'b010;
        if (b >= r + 4 && b >= g + 4) return 3'b001;
        return 3'b000;
    endfunction

    function automatic logic [2:0] m_decide(input int r, input int g, input int b);
        if (r >= 64 && r > g && r > b) return 3'b100;
        if (g >= 64 && g > r && g > b) return 3'b010;
        if (b >= 64 && b > r && b > g) return 3'b001;
        return 3'b000;
    endfunction

    function automatic logic [15:0] rnd_px(input int kind);
        case (kind)
            1: return {5'($urandom_range(8, 31)), 6'($urandom_range(0, 15)), 5'($urandom_range(0, 7))};
            2: return {5'($urandom_range(0, 7)), 6'($urandom_range(16, 63)), 5'($urandom_range(0, 7))};
            3: return {5'($urandom_range(0, 7)), 6'($urandom_range(0, 15)), 5'($urandom_range(8, 31))};
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk) camera_data = b;
        repeat (2) @(negedge clk);
        pclk = 1'b1;
        repeat (3) @(negedge clk);
        pclk = 1'b0;
    endtask

    task automatic px(input logic [15:0] p);
        send_byte(p[15:8]);
        send_byte(p[7:0]);
    endtask

    task automatic line(input logic [15:0] p, input int n);
        @(negedge clk) href = 1'b1;
        repeat (n) px(p);
        @(negedge clk) href = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic end_frame(output logic [2:0] code);
        @(negedge clk) vsync = 1'b1;
        repeat (4) @(posedge clk);
        #1 code = color_code;
        repeat (4) @(negedge clk);
        vsync = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset;
        int last, nchg, bad;
        logic prev;
        reset = 1'b1;
        repeat (5) @(negedge clk);
        tests++;
        if (color_code !== 3'b000) begin fails++; $display("FAIL reset_code got %b want 000", color_code); end
        tests++;
        if (xclk !== 1'b0) begin fails++; $display("FAIL reset_xclk got %b want 0", xclk); end
        reset = 1'b0;
        prev = xclk;
        last = 0;
        nchg = 0;
        bad = 0;
        for (int i = 1; i <= 24; i++) begin
            @(negedge clk);
            if (xclk !== prev) begin
                if (i - last != 2) bad++;
                last = i;
                nchg++;
            end
            prev = xclk;
        end
        tests++;
        if (bad != 0 || nchg != 12) begin fails++; $display("FAIL xclk_period bad_gaps %0d toggles %0d want 0 and 12", bad, nchg); end
    endtask

    task automatic test_primaries;
        logic [2:0] c;
        line(16'hF800, 100);
        end_frame(c);
        tests++;
        if (c !== 3'b100) begin fails++; $display("FAIL red_frame got %b want 100", c); end
        line(16'h07E0, 100);
        end_frame(c);
        tests++;
        if (c !== 3'b010) begin fails++; $display("FAIL green_frame got %b want 010", c); end
        line(16'h001F, 100);
        end_frame(c);
        tests++;
        if (c !== 3'b001) begin fails++; $display("FAIL blue_frame got %b want 001", c); end
    endtask

    task automatic test_thresholds;
        logic [2:0] c;
        line(16'hF800, 50);
        line(16'h8410, 200);
        end_frame(c);
        tests++;
        if (c !== 3'b000) begin fails++; $display("FAIL below_min got %b want 000", c); end
        line(16'hF800, 80);
        line(16'h001F, 80);
        end_frame(c);
        tests++;
        if (c !== 3'b000) begin fails++; $display("FAIL tie got %b want 000", c); end
        line(16'h001F, 64);
        end_frame(c);
        tests++;
        if (c !== 3'b001) begin fails++; $display("FAIL min_exact got %b want 001", c); end
        line(16'h001F, 63);
        end_frame(c);
        tests++;
        if (c !== 3'b000) begin fails++; $display("FAIL min_minus1 got %b want 000", c); end
    endtask

    task automatic test_margin;
        logic [2:0] c;
        line(16'h2000, 70);
        end_frame(c);
        tests++;
        if (c !== 3'b100) begin fails++; $display("FAIL margin_exact got %b want 100", c); end
        line(16'h1800, 70);
        end_frame(c);
        tests++;
        if (c !== 3'b000) begin fails++; $display("FAIL margin_short got %b want 000", c); end
    endtask

    task automatic test_blanking;
        logic [2:0] c;
        line(16'hF800, 100);
        @(negedge clk) vsync = 1'b1;
        repeat (6) @(negedge clk);
        line(16'h001F, 100);
        tests++;
        if (color_code !== 3'b100) begin fails++; $display("FAIL blank_hold got %b want 100", color_code); end
        vsync = 1'b0;
        repeat (4) @(negedge clk);
        end_frame(c);
        tests++;
        if (c !== 3'b000) begin fails++; $display("FAIL blank_ignored got %b want 000", c); end
    endtask

    task automatic test_odd_byte;
        logic [2:0] c;
        repeat (7) begin
            @(negedge clk) href = 1'b1;
            repeat (10) px(16'h07E0);
            send_byte(8'hF8);
            @(negedge clk) href = 1'b0;
            repeat (4) @(negedge clk);
        end
        end_frame(c);
        tests++;
        if (c !== 3'b010) begin fails++; $display("FAIL odd_byte got %b want 010", c); end
    endtask

    task automatic test_reset_mid;
        logic [2:0] c;
        line(16'hF800, 100);
        end_frame(c);
        tests++;
        if (c !== 3'b100) begin fails++; $display("FAIL pre_reset got %b want 100", c); end
        line(16'hF800, 90);
        @(negedge clk) reset = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if (color_code !== 3'b000) begin fails++; $display("FAIL mid_reset_code got %b want 000", color_code); end
        reset = 1'b0;
        line(16'hF800, 10);
        end_frame(c);
        tests++;
        if (c !== 3'b000) begin fails++; $display("FAIL post_reset got %b want 000", c); end
    endtask

    task automatic test_random;
        logic [2:0] c, exp;
        logic [15:0] p;
        int cnt[3];
        int n, bias, kind;
        for (int f = 0; f < 6; f++) begin
            cnt = '{0, 0, 0};
            n = $urandom_range(40, 150);
            bias = $urandom_range(0, 3);
            @(negedge clk) href = 1'b1;
            for (int i = 0; i < n; i++) begin
                kind = ($urandom_range(0, 9) < 6) ? bias : $urandom_range(0, 3);
                p = rnd_px(kind);
                case (m_class(p))
                    3'b100: cnt[0]++;
                    3'b010: cnt[1]++;
                    3'b001: cnt[2]++;
                    default: ;
                endcase
                px(p);
            end
            @(negedge clk) href = 1'b0;
            repeat (4) @(negedge clk);
            exp = m_decide(cnt[0], cnt[1], cnt[2]);
            end_frame(c);
            tests++;
            if (c !== exp) begin
                fails++;
                $display("FAIL random_frame%0d got %b want %b (r%0d g%0d b%0d)", f, c, exp, cnt[0], cnt[1], cnt[2]);
            end
        end
    endtask

    initial begin
        test_reset;
        test_primaries;
        test_thresholds;
        test_margin;
        test_blanking;
        test_odd_byte;
        test_reset_mid;
        test_random;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
